if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline stage directly downstream of the instruction unit.
- Latches the fetched IR and PC, and detects load-use hazards against the instruction in EX.
- Flushes on branch/jump/JR redirects and halts on BREAK.
- Drives pc_ld, ir_ld and nop back to the instruction unit and presents a decoded register pair to the regfile.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- BRK_FUNCT, 6'h0D, funct code of BREAK (opcode 6'h00).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- IR_in  input  32  IR_out from the instruction unit.
- PC_in  input  32  PC_out from the instruction unit.
- ext_stall  input  1  stall from the memory system; freezes the front end.
- redirect  input  1  branch taken / jump / JR resolved in EX, single-cycle pulse.
- id_ex_mem_rd  input  1  instruction in EX is a load.
- id_ex_rt  input  5  destination register of that load.
- resume  input  1  leave HALT, single-cycle pulse.
- IF_ID_IR  output  32  registered instruction in decode.
- IF_ID_PC  output  32  registered PC of that instruction.
- IF_ID_valid  output  1  IF_ID_IR is a real, non-squashed instruction.
- rs_addr  output  5  IF_ID_IR[25:21].
- rt_addr  output  5  IF_ID_IR[20:16].
- pc_ld  output  1  PC load enable to the instruction unit.
- ir_ld  output  1  IR load enable to the instruction unit.
- nop  output  1  forces the instruction unit IR to zero at the next edge.
- id_bubble  output  1  the ID/EX stage must load a bubble this cycle.
- halted  output  1  block is in HALT.
- stall_cnt  output  CNT_W  saturating count of hazard plus ext_stall cycles.
- flush_cnt  output  CNT_W  saturating count of redirects.

Behaviour:
- Reset (rst=0, async):
  - State is RUN.
  - IF_ID_IR=0, IF_ID_PC=0, IF_ID_valid=0.
  - Both counters are 0.
  - Combinational outputs follow from the reset state: pc_ld=ir_ld=1, nop=0, id_bubble=0, halted=0.
- hazard = id_ex_mem_rd & (id_ex_rt!=0) & IF_ID_valid & (id_ex_rt==rs_addr | id_ex_rt==rt_addr).
- brk = IF_ID_valid & IF_ID_IR[31:26]==0 & IF_ID_IR[5:0]==BRK_FUNCT.
- States: RUN, FLUSH, HALT. Outputs are combinational from state and inputs. Registers update on the rising edge.
- Priority in RUN and FLUSH: redirect > ext_stall > hazard > brk.
- RUN, redirect=1:
  - pc_ld=1, ir_ld=1, nop=1, id_bubble=1.
  - Next edge: IF_ID_IR=0, IF_ID_valid=0, go to FLUSH, flush_cnt+1.
- RUN, ext_stall=1:
  - pc_ld=0, ir_ld=0, id_bubble=1.
  - IF_ID holds; stall_cnt+1.
- RUN, hazard=1:
  - pc_ld=0, ir_ld=0, id_bubble=1.
  - IF_ID holds; stall_cnt+1.
  - Next cycle the load has advanced, so hazard drops and the stall lasts exactly 1 cycle.
- RUN, brk=1:
  - pc_ld=0, ir_ld=0, id_bubble=0; BREAK is issued once.
  - Next edge: IF_ID_valid=0, go to HALT.
- RUN, none of the above:
  - pc_ld=1, ir_ld=1.
  - Next edge: IF_ID_IR<=IR_in, IF_ID_PC<=PC_in, IF_ID_valid=1.
- FLUSH:
  - Lasts one cycle. The instruction unit IR holds 0 from nop.
  - Behaves as RUN, except IF_ID_valid is loaded with 0 when IF_ID loads.
  - Returns to RUN.
  - A redirect in FLUSH restarts FLUSH and counts again.
  - ext_stall in FLUSH holds the state in FLUSH.
- HALT:
  - pc_ld=0, ir_ld=0, id_bubble=1, halted=1.
  - IF_ID holds with valid=0.
  - resume=1: go to RUN; IF_ID loads IR_in on the same edge.
  - redirect in HALT is ignored.
- Counters saturate at all-ones and never wrap.
- Only one counter can increment per cycle.
- rs_addr and rt_addr are pure slices of IF_ID_IR.
- Reset mid-stall, mid-flush or mid-halt returns everything to reset values immediately, without waiting for a clock.

Test Plan:
- Reset: rst=0 for 2 cycles, then release, then IR_in=32'h8C220004 (lw r2,4(r1)), PC_in=32'h40 -> during reset all registered outputs are 0; one edge after release IF_ID_IR=32'h8C220004, IF_ID_PC=32'h40, IF_ID_valid=1.
- Load-use: IF_ID holds add r3,r2,r4 (32'h00441820); id_ex_mem_rd=1, id_ex_rt=2 -> exactly 1 cycle with pc_ld=ir_ld=0 and id_bubble=1, IF_ID unchanged, stall_cnt=1; same setup with id_ex_rt=0 -> no stall.
- Redirect: pulse redirect for 1 cycle -> nop=1 that cycle; next cycle IF_ID_IR=0, IF_ID_valid=0, state FLUSH; following cycle back in RUN; flush_cnt=1.
- Priority: redirect and hazard in the same cycle -> flush taken, stall_cnt unchanged; ext_stall and hazard together -> stall_cnt incremented once.
- BREAK: IF_ID_IR=32'h0000000D -> halted=1 from the next cycle, pc_ld=0; redirect during HALT has no effect; resume pulse -> RUN, and the next IR_in is loaded on the same edge.
- Saturation and async reset: hold ext_stall for 2^16+5 cycles -> stall_cnt=16'hFFFF; drop rst between clock edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/if_id_if.sv
// Handshake/bus bundle between the instruction unit, the IF/ID stage and its neighbours.
// The master side drives fetch/EX-side inputs; the slave side is the IF/ID stage itself.
interface if_id_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      IR_in;
   logic [31:0]      PC_in;
   logic             ext_stall;
   logic             redirect;
   logic             id_ex_mem_rd;
   logic [4:0]       id_ex_rt;
   logic             resume;

   logic [31:0]      IF_ID_IR;
   logic [31:0]      IF_ID_PC;
   logic             IF_ID_valid;
   logic [4:0]       rs_addr;
   logic [4:0]       rt_addr;
   logic             pc_ld;
   logic             ir_ld;
   logic             nop;
   logic             id_bubble;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output IR_in, PC_in, ext_stall, redirect, id_ex_mem_rd, id_ex_rt, resume,
      input  IF_ID_IR, IF_ID_PC, IF_ID_valid, rs_addr, rt_addr,
      input  pc_ld, ir_ld, nop, id_bubble, halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  IR_in, PC_in, ext_stall, redirect, id_ex_mem_rd, id_ex_rt, resume,
      output IF_ID_IR, IF_ID_PC, IF_ID_valid, rs_addr, rt_addr,
      output pc_ld, ir_ld, nop, id_bubble, halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard stall, redirect flush, BREAK halt
// and saturating stall/flush performance counters.
//
// state | meaning
// RUN   | normal fetch/decode flow
// FLUSH | one cycle after a redirect; the squashed slot is loaded as invalid
// HALT  | BREAK retired; front end frozen until resume
module if_id_stage #(
   parameter int          CNT_W     = 16,
   parameter logic [5:0]  BRK_FUNCT = 6'h0D
) (
   input logic    clk,
   input logic    rst,
   if_id_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t           r_state;
   logic [31:0]      r_ir;
   logic [31:0]      r_pc;
   logic             r_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_hazard;
   logic             w_brk;
   logic             w_pc_ld;
   logic             w_ir_ld;
   logic             w_nop;
   logic             w_bubble;
   logic             w_halted;

   assign w_hazard = bus.id_ex_mem_rd && (bus.id_ex_rt != 5'd0) && r_valid &&
                     ((bus.id_ex_rt == r_ir[25:21]) || (bus.id_ex_rt == r_ir[20:16]));
   assign w_brk    = r_valid && (r_ir[31:26] == 6'd0) && (r_ir[5:0] == BRK_FUNCT);

   always_comb begin
      w_pc_ld  = 1'b1;
      w_ir_ld  = 1'b1;
      w_nop    = 1'b0;
      w_bubble = 1'b0;
      w_halted = 1'b0;
      case (r_state)
         ST_HALT: begin
            // on resume the front end advances together with the IF/ID load
            w_pc_ld  = bus.resume;
            w_ir_ld  = bus.resume;
            w_bubble = 1'b1;
            w_halted = 1'b1;
         end
         default: begin
            if (bus.redirect) begin
               w_nop    = 1'b1;
               w_bubble = 1'b1;
            end else if (bus.ext_stall || w_hazard) begin
               w_pc_ld  = 1'b0;
               w_ir_ld  = 1'b0;
               w_bubble = 1'b1;
            end else if (w_brk) begin
               w_pc_ld  = 1'b0;
               w_ir_ld  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_ir        <= '0;
         r_pc        <= '0;
         r_valid     <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         case (r_state)
            ST_HALT: begin
               if (bus.resume) begin
                  r_ir    <= bus.IR_in;
                  r_pc    <= bus.PC_in;
                  r_valid <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            default: begin
               if (bus.redirect) begin
                  r_ir    <= '0;
                  r_valid <= 1'b0;
                  r_state <= ST_FLUSH;
                  if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
               end else if (bus.ext_stall || w_hazard) begin
                  if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
               end else if (w_brk) begin
                  r_valid <= 1'b0;
                  r_state <= ST_HALT;
               end else begin
                  // the slot fetched during FLUSH is the nop the IU was forced to
                  r_ir    <= bus.IR_in;
                  r_pc    <= bus.PC_in;
                  r_valid <= (r_state == ST_RUN);
                  r_state <= ST_RUN;
               end
            end
         endcase
      end
   end

   assign bus.IF_ID_IR    = r_ir;
   assign bus.IF_ID_PC    = r_pc;
   assign bus.IF_ID_valid = r_valid;
   assign bus.rs_addr     = r_ir[25:21];
   assign bus.rt_addr     = r_ir[20:16];
   assign bus.pc_ld       = w_pc_ld;
   assign bus.ir_ld       = w_ir_ld;
   assign bus.nop         = w_nop;
   assign bus.id_bubble   = w_bubble;
   assign bus.halted      = w_halted;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, randomized run against
// a behavioural model, counter saturation and asynchronous reset corner cases.
module tb_if_id_stage;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   if_id_if #(.CNT_W(CNT_W)) bus ();

   if_id_stage #(.CNT_W(CNT_W), .BRK_FUNCT(6'h0D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit red, input bit stl, input bit mrd, input logic [4:0] rt,
                        input bit res, input logic [31:0] ir, input logic [31:0] pc);
      bus.redirect     = red;
      bus.ext_stall    = stl;
      bus.id_ex_mem_rd = mrd;
      bus.id_ex_rt     = rt;
      bus.resume       = res;
      bus.IR_in        = ir;
      bus.PC_in        = pc;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ir"},     bus.IF_ID_IR, 32'h0);
      check({tag, "_pc"},     bus.IF_ID_PC, 32'h0);
      check({tag, "_valid"},  32'(bus.IF_ID_valid), 32'h0);
      check({tag, "_stall"},  32'(bus.stall_cnt), 32'h0);
      check({tag, "_flush"},  32'(bus.flush_cnt), 32'h0);
      check({tag, "_pc_ld"},  32'(bus.pc_ld), 32'h1);
      check({tag, "_ir_ld"},  32'(bus.ir_ld), 32'h1);
      check({tag, "_nop"},    32'(bus.nop), 32'h0);
      check({tag, "_bubble"}, 32'(bus.id_bubble), 32'h0);
      check({tag, "_halted"}, 32'(bus.halted), 32'h0);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_ir, m_pc;
   bit          m_valid, m_halt, m_after_redirect;
   int          m_stall, m_flush;

   task automatic model_reset();
      m_ir = 0; m_pc = 0; m_valid = 0; m_halt = 0; m_after_redirect = 0;
      m_stall = 0; m_flush = 0;
   endtask

   function automatic bit m_hazard(input bit mrd, input logic [4:0] rt);
      return mrd && rt != 0 && m_valid && (rt == m_ir[25:21] || rt == m_ir[20:16]);
   endfunction

   function automatic bit m_break();
      return m_valid && m_ir[31:26] == 0 && m_ir[5:0] == 6'h0D;
   endfunction

   // {pc_ld, ir_ld, nop, id_bubble, halted}
   function automatic logic [4:0] model_comb(input bit red, input bit stl, input bit mrd,
                                             input logic [4:0] rt, input bit res);
      if (m_halt)                         return {res, res, 1'b0, 1'b1, 1'b1};
      if (red)                            return 5'b11110;
      if (stl || m_hazard(mrd, rt))       return 5'b00010;
      if (m_break())                      return 5'b00000;
      return 5'b11000;
   endfunction

   task automatic model_edge(input bit red, input bit stl, input bit mrd, input logic [4:0] rt,
                             input bit res, input logic [31:0] ir, input logic [31:0] pc);
      if (m_halt) begin
         if (res) begin
            m_ir = ir; m_pc = pc; m_valid = 1; m_halt = 0;
         end
      end else if (red) begin
         m_ir = 0; m_valid = 0; m_after_redirect = 1;
         m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
      end else if (stl || m_hazard(mrd, rt)) begin
         m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
      end else if (m_break()) begin
         m_valid = 0; m_halt = 1; m_after_redirect = 0;
      end else begin
         m_ir = ir; m_pc = pc; m_valid = !m_after_redirect; m_after_redirect = 0;
      end
   endtask

   function automatic logic [31:0] rnd_ir();
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt;
      logic [31:0] mid;
      op  = ($urandom_range(1) == 1) ? 6'h23 : 6'h00;
      rs  = 5'($urandom_range(3));
      rt  = 5'($urandom_range(3));
      mid = $urandom;
      fn  = ($urandom_range(3) == 0) ? 6'h0D : 6'($urandom);
      return {op, rs, rt, mid[9:0], fn};
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        red, stl, mrd;
      logic [4:0]  rt;
      logic        res;
      logic [31:0] ir, pc;
      logic [4:0]  comb;
      logic [31:0] q_ir;
      logic        q_v;
      int          q_stall, q_flush;
   } vec_t;

   function automatic vec_t mk(input bit red, input bit stl, input bit mrd, input logic [4:0] rt,
                               input bit res, input logic [31:0] ir, input logic [31:0] pc,
                               input logic [4:0] comb, input logic [31:0] q_ir, input bit q_v,
                               input int q_stall, input int q_flush);
      vec_t v;
      v.red = red; v.stl = stl; v.mrd = mrd; v.rt = rt; v.res = res; v.ir = ir; v.pc = pc;
      v.comb = comb; v.q_ir = q_ir; v.q_v = q_v; v.q_stall = q_stall; v.q_flush = q_flush;
      return v;
   endfunction

   localparam int NV = 16;
   vec_t tbl [NV];

   initial begin
      vec_t v;
      logic [4:0] e;
      bit r_red, r_stl, r_mrd, r_res;
      logic [4:0] r_rt;
      logic [31:0] r_ir, r_pc;

      tbl[0]  = mk(0,0,0,0,0, 32'h00441820, 32'h44, 5'b11000, 32'h00441820, 1, 0, 0);
      tbl[1]  = mk(0,0,1,2,0, 32'h11111111, 32'h48, 5'b00010, 32'h00441820, 1, 1, 0);
      tbl[2]  = mk(0,0,1,0,0, 32'h00622020, 32'h48, 5'b11000, 32'h00622020, 1, 1, 0);
      tbl[3]  = mk(1,0,1,3,0, 32'h22222222, 32'h4C, 5'b11110, 32'h0,        0, 1, 1);
      tbl[4]  = mk(0,0,0,0,0, 32'h0,        32'h80, 5'b11000, 32'h0,        0, 1, 1);
      tbl[5]  = mk(0,0,0,0,0, 32'h0000000D, 32'h84, 5'b11000, 32'h0000000D, 1, 1, 1);
      tbl[6]  = mk(0,0,0,0,0, 32'h12345678, 32'h88, 5'b00000, 32'h0000000D, 0, 1, 1);
      tbl[7]  = mk(1,0,0,0,0, 32'h12345678, 32'h88, 5'b00011, 32'h0000000D, 0, 1, 1);
      tbl[8]  = mk(0,0,0,0,1, 32'h8C220004, 32'h8C, 5'b11011, 32'h8C220004, 1, 1, 1);
      tbl[9]  = mk(0,1,1,2,0, 32'h33333333, 32'h90, 5'b00010, 32'h8C220004, 1, 2, 1);
      tbl[10] = mk(0,0,0,0,0, 32'h00441820, 32'h90, 5'b11000, 32'h00441820, 1, 2, 1);
      tbl[11] = mk(1,0,0,0,0, 32'h44444444, 32'h94, 5'b11110, 32'h0,        0, 2, 2);
      tbl[12] = mk(1,0,0,0,0, 32'h55555555, 32'h98, 5'b11110, 32'h0,        0, 2, 3);
      tbl[13] = mk(0,1,0,0,0, 32'h0,        32'h9C, 5'b00010, 32'h0,        0, 3, 3);
      tbl[14] = mk(0,0,0,0,0, 32'h00441820, 32'h9C, 5'b11000, 32'h00441820, 0, 3, 3);
      tbl[15] = mk(0,0,0,0,0, 32'h00622020, 32'hA0, 5'b11000, 32'h00622020, 1, 3, 3);

      // reset held for two cycles, then first instruction latched one edge after release
      drive(0,0,0,0,0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      rst = 1'b1;
      drive(0,0,0,0,0, 32'h8C220004, 32'h40);
      @(posedge clk); #1;
      check("rst_rel_ir", bus.IF_ID_IR, 32'h8C220004);
      check("rst_rel_pc", bus.IF_ID_PC, 32'h40);
      check("rst_rel_valid", 32'(bus.IF_ID_valid), 32'h1);

      for (int i = 0; i < NV; i++) begin
         v = tbl[i];
         drive(v.red, v.stl, v.mrd, v.rt, v.res, v.ir, v.pc);
         #2;
         check($sformatf("vec%0d_ctl", i),
               {27'd0, bus.pc_ld, bus.ir_ld, bus.nop, bus.id_bubble, bus.halted}, 32'(v.comb));
         @(posedge clk); #1;
         check($sformatf("vec%0d_ir", i), bus.IF_ID_IR, v.q_ir);
         check($sformatf("vec%0d_valid", i), 32'(bus.IF_ID_valid), 32'(v.q_v));
         check($sformatf("vec%0d_stall", i), 32'(bus.stall_cnt), 32'(v.q_stall));
         check($sformatf("vec%0d_flush", i), 32'(bus.flush_cnt), 32'(v.q_flush));
      end

      // randomized run against the model
      rst = 1'b0;
      drive(0,0,0,0,0, 32'h0, 32'h0);
      #1;
      check_reset("rnd_rst");
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 500; c++) begin
         r_red = ($urandom_range(7) == 0);
         r_stl = ($urandom_range(7) == 0);
         r_mrd = ($urandom_range(1) == 1);
         r_rt  = 5'($urandom_range(3));
         r_res = ($urandom_range(3) == 0);
         r_ir  = rnd_ir();
         r_pc  = $urandom;
         drive(r_red, r_stl, r_mrd, r_rt, r_res, r_ir, r_pc);
         #2;
         e = model_comb(r_red, r_stl, r_mrd, r_rt, r_res);
         check($sformatf("rnd%0d_ctl", c),
               {27'd0, bus.pc_ld, bus.ir_ld, bus.nop, bus.id_bubble, bus.halted}, 32'(e));
         check($sformatf("rnd%0d_rs", c), 32'(bus.rs_addr), 32'(m_ir[25:21]));
         check($sformatf("rnd%0d_rt", c), 32'(bus.rt_addr), 32'(m_ir[20:16]));
         @(posedge clk);
         model_edge(r_red, r_stl, r_mrd, r_rt, r_res, r_ir, r_pc);
         #1;
         check($sformatf("rnd%0d_ir", c), bus.IF_ID_IR, m_ir);
         check($sformatf("rnd%0d_pc", c), bus.IF_ID_PC, m_pc);
         check($sformatf("rnd%0d_valid", c), 32'(bus.IF_ID_valid), 32'(m_valid));
         check($sformatf("rnd%0d_stall", c), 32'(bus.stall_cnt), 32'(m_stall));
         check($sformatf("rnd%0d_flush", c), 32'(bus.flush_cnt), 32'(m_flush));
      end

      // stall counter saturation, then asynchronous reset mid-stall
      rst = 1'b0;
      drive(0,0,0,0,0, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(0,1,0,0,0, 32'h0, 32'h0);
      repeat (65536 + 5) @(posedge clk);
      #1;
      check("sat_stall", 32'(bus.stall_cnt), 32'h0000FFFF);
      check("sat_flush", 32'(bus.flush_cnt), 32'h0);
      #2;
      rst = 1'b0;
      drive(0,0,0,0,0, 32'h0, 32'h0);
      #1;
      check_reset("async_stall");

      // asynchronous reset while halted
      @(posedge clk); #1;
      rst = 1'b1;
      drive(0,0,0,0,0, 32'h0000000D, 32'h100);
      @(posedge clk); #1;
      drive(0,0,0,0,0, 32'h0, 32'h104);
      @(posedge clk); #1;
      check("halt_before_rst", 32'(bus.halted), 32'h1);
      check("halt_ir_before_rst", bus.IF_ID_IR, 32'h0000000D);
      #2;
      rst = 1'b0;
      #1;
      check_reset("async_halt");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
